// File: rtl/rf_pkg.sv
// Shared register-file types: data/address widths and the write request.
// Used by the writeback merger and the register file itself.
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // One-hot register mask; x0 maps to an empty mask.
  function automatic logic [NREG-1:0] rd_mask(
    input logic [REG_AW-1:0] rd
  );
    rd_mask = '0;
    if (rd != '0) rd_mask[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of wb_req_t for buffered load writebacks.
// Ports: push/din, pop/dout (head), full, empty, count.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  wb_req_t    din,
  input  logic       pop,
  output wb_req_t    dout,
  output logic       full,
  output logic       empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t      r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  // Extra MSB distinguishes full from empty when indices match.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                 (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count = r_wptr - r_rptr;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign dout = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU results and buffered loads into the single RF write port,
// and tracks outstanding loads per register. Ports: alu_*, ld_*, issue_*,
// wb_we/wb_addr/wb_data, pending. Optional RF_WB_FORWARD_EN adds
// fwd_valid/fwd_addr/fwd_data and pending_next.
module regfile_writeback
  import rf_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_ld,
  input  logic [4:0]  issue_rd,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] pending
`ifdef RF_WB_FORWARD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic [31:0] pending_next
`endif
);

  localparam int CW = $clog2(LD_DEPTH) + 1;

  wb_req_t       w_din;
  wb_req_t       w_head;
  wb_req_t       w_req;
  logic          w_req_v;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;
  logic [31:0]   w_pend_nxt;

  logic          r_we;
  logic [4:0]    r_addr;
  logic [31:0]   r_data;
  logic [31:0]   r_pend;

  // Ready depends only on registered occupancy; held low in reset.
  assign ld_ready = rst_n && (w_count < CW'(LD_DEPTH));
  assign w_push   = ld_valid && ld_ready && !w_full;
  assign w_din    = '{addr: ld_rd, data: ld_data};

  // ALU owns the port whenever it is active.
  assign w_pop = !alu_valid && !w_empty;

  wb_fifo #(
    .DEPTH (LD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_req_v = 1'b0;
    w_req   = '0;
    unique case (1'b1)
      alu_valid: begin
        w_req_v   = 1'b1;
        w_req     = '{addr: alu_rd, data: alu_data};
      end
      w_pop: begin
        w_req_v = 1'b1;
        w_req   = w_head;
      end
      default: ;
    endcase
  end

  // Set after clear so a same-cycle reissue keeps the bit.
  assign w_set      = issue_ld ? rd_mask(issue_rd) : '0;
  assign w_clr      = w_pop ? rd_mask(w_head.addr) : '0;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      // x0 writes are consumed silently.
      if (w_req_v && (w_req.addr != '0)) begin
        r_we   <= 1'b1;
        r_addr <= w_req.addr;
        r_data <= w_req.data;
      end else begin
        r_we   <= 1'b0;
        r_addr <= '0;
        r_data <= '0;
      end
    end
  end

  assign wb_we   = r_we;
  assign wb_addr = r_addr;
  assign wb_data = r_data;
  assign pending = r_pend;

`ifdef RF_WB_FORWARD_EN
  assign fwd_valid    = r_we;
  assign fwd_addr     = r_addr;
  assign fwd_data     = r_data;
  assign pending_next = w_pend_nxt;
`endif

endmodule
